fmap_stream_tx: RTL and testbench

FMAP_STREAM_TX -- requirements
Module: fmap_stream_tx

---
 rtl/fmap_pkg.sv | 17 +
 rtl/fmap_idx_counter.sv | 98 +++++++++
 rtl/fmap_stream_tx.sv | 138 +++++++++++++
 tb/tb_fmap_stream_tx.sv | 211 +++++++++++++++++++++
 4 files changed

// File: rtl/fmap_pkg.sv
// Shared definitions for the feature-map stream transmitter: word width,
// FSM state encoding and a width helper for index ports.
package fmap_pkg;

  localparam int DATA_WIDTH = 16;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    SEND = 1'b1
  } state_t;

  // Index ports never collapse to zero bits, even for a single channel/word.
  function automatic int clog2_min1(input int value);
    return (value > 1) ? $clog2(value) : 1;
  endfunction

endpackage

// File: rtl/fmap_idx_counter.sv
// Word index counter with wrap on the final word, plus optional channel
// tracking (built only when FMAP_STREAM_TX_CHLAST_EN is defined).
module fmap_idx_counter
  import fmap_pkg::*;
#(
  parameter int C = 2,
  parameter int H = 2,
  parameter int W = 2,
  localparam int N      = C * H * W,
  localparam int CNT_W  = $clog2(N) + 1,
  localparam int ADDR_W = clog2_min1(N),
  localparam int CH_W   = clog2_min1(C)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic [ADDR_W-1:0] word_addr,
  output logic              word_last,
  output logic [CH_W-1:0]   ch_idx,
  output logic              ch_last
);

  logic [CNT_W-1:0] word_q, word_d;

  // Next word index: advance on each transfer, wrap after word N-1.
  always_comb begin
    word_d = word_q;
    if (en) begin
      if (word_q == CNT_W'(N - 1)) begin
        word_d = {CNT_W{1'b0}};
      end else begin
        word_d = word_q + CNT_W'(1);
      end
    end else begin
      word_d = word_q;
    end
  end

  // Word index register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      word_q <= {CNT_W{1'b0}};
    end else begin
      word_q <= word_d;
    end
  end

  assign word_addr = word_q[ADDR_W-1:0];
  assign word_last = (word_q == CNT_W'(N - 1));

`ifdef FMAP_STREAM_TX_CHLAST_EN
  localparam int PLANE = H * W;
  localparam int PIX_W = clog2_min1(PLANE);

  logic [PIX_W-1:0] pix_q, pix_d;
  logic [CH_W-1:0]  ch_q, ch_d;

  // Position within the current plane and plane number.
  always_comb begin
    pix_d = pix_q;
    ch_d  = ch_q;
    if (en) begin
      if (pix_q == PIX_W'(PLANE - 1)) begin
        pix_d = {PIX_W{1'b0}};
        if (ch_q == CH_W'(C - 1)) begin
          ch_d = {CH_W{1'b0}};
        end else begin
          ch_d = ch_q + CH_W'(1);
        end
      end else begin
        pix_d = pix_q + PIX_W'(1);
        ch_d  = ch_q;
      end
    end else begin
      pix_d = pix_q;
      ch_d  = ch_q;
    end
  end

  // Channel tracking registers.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pix_q <= {PIX_W{1'b0}};
      ch_q  <= {CH_W{1'b0}};
    end else begin
      pix_q <= pix_d;
      ch_q  <= ch_d;
    end
  end

  assign ch_idx  = ch_q;
  assign ch_last = (pix_q == PIX_W'(PLANE - 1));
`else
  assign ch_idx  = {CH_W{1'b0}};
  assign ch_last = 1'b0;
`endif

endmodule

// File: rtl/fmap_stream_tx.sv
// Captures a flattened C x H x W FP16 feature map and streams it word by word
// over a valid/ready port. Channel sideband enabled by FMAP_STREAM_TX_CHLAST_EN.
module fmap_stream_tx
  import fmap_pkg::*;
#(
  parameter int C = 2,
  parameter int H = 2,
  parameter int W = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                load,
  input  logic [0:C*H*W*DATA_WIDTH-1]         fmap,
  output logic                                busy,
  output logic                                load_err,
  output logic                                m_valid,
  input  logic                                m_ready,
  output logic [DATA_WIDTH-1:0]               m_data,
  output logic [clog2_min1(C)-1:0]            m_ch_idx,
  output logic                                m_ch_last,
  output logic                                m_last
);

  localparam int N      = C * H * W;
  localparam int ADDR_W = clog2_min1(N);
  localparam int CH_W   = clog2_min1(C);

  state_t                state_q, state_d;
  logic [DATA_WIDTH-1:0] buf_q [N];
  logic [DATA_WIDTH-1:0] buf_d [N];
  logic [DATA_WIDTH-1:0] m_data_q, m_data_d;
  logic                  load_err_q, load_err_d;
  logic                  busy_s, xfer_s, word_last_s, ch_last_s;
  logic [ADDR_W-1:0]     word_addr_s, nxt_addr_s;
  logic [CH_W-1:0]       ch_idx_s;

  fmap_idx_counter #(.C(C), .H(H), .W(W)) u_idx (
    .clk       (clk),
    .reset     (reset),
    .en        (xfer_s),
    .word_addr (word_addr_s),
    .word_last (word_last_s),
    .ch_idx    (ch_idx_s),
    .ch_last   (ch_last_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next state.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = load ? SEND : IDLE;
      SEND:    state_d = (xfer_s && word_last_s) ? IDLE : SEND;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    busy_s = 1'b0;
    case (state_q)
      IDLE:    busy_s = 1'b0;
      SEND:    busy_s = 1'b1;
      default: busy_s = 1'b0;
    endcase
  end

  assign xfer_s     = busy_s && m_ready;
  assign nxt_addr_s = word_addr_s + ADDR_W'(1);

  // Capture, output word preload and ignored-load detection.
  always_comb begin
    buf_d      = buf_q;
    m_data_d   = m_data_q;
    load_err_d = 1'b0;
    case (state_q)
      IDLE: begin
        if (load) begin
          for (int k = 0; k < N; k++) begin
            buf_d[k] = fmap[k*DATA_WIDTH +: DATA_WIDTH];
          end
          m_data_d = fmap[0 +: DATA_WIDTH];
        end else begin
          m_data_d = m_data_q;
        end
      end
      SEND: begin
        load_err_d = load;
        if (xfer_s) begin
          if (word_last_s) begin
            m_data_d = {DATA_WIDTH{1'b0}};
          end else begin
            m_data_d = buf_q[nxt_addr_s];
          end
        end else begin
          m_data_d = m_data_q;
        end
      end
      default: begin
        m_data_d   = {DATA_WIDTH{1'b0}};
        load_err_d = 1'b0;
      end
    endcase
  end

  // Frame buffer holds data only; no reset needed.
  always_ff @(posedge clk) begin
    buf_q <= buf_d;
  end

  // Registered stream word and error pulse.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      m_data_q   <= {DATA_WIDTH{1'b0}};
      load_err_q <= 1'b0;
    end else begin
      m_data_q   <= m_data_d;
      load_err_q <= load_err_d;
    end
  end

  assign busy      = busy_s;
  assign m_valid   = busy_s;
  assign m_data    = m_data_q;
  assign load_err  = load_err_q;
  assign m_last    = busy_s & word_last_s;
  assign m_ch_last = busy_s & ch_last_s;
  assign m_ch_idx  = busy_s ? ch_idx_s : {CH_W{1'b0}};

endmodule

// File: tb/tb_fmap_stream_tx.sv
// Directed bench for fmap_stream_tx with C=H=W=2 (8 words per frame).
module tb_fmap_stream_tx;

  localparam int C  = 2;
  localparam int H  = 2;
  localparam int W  = 2;
  localparam int N  = C * H * W;
  localparam int DW = 16;

  logic            clk = 1'b0;
  logic            reset;
  logic            load;
  logic            m_ready;
  logic [0:N*DW-1] fmap;
  logic            busy, load_err, m_valid, m_ch_last, m_last;
  logic [DW-1:0]   m_data;
  logic [0:0]      m_ch_idx;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  fmap_stream_tx #(.C(C), .H(H), .W(W)) dut (
    .clk       (clk),
    .reset     (reset),
    .load      (load),
    .fmap      (fmap),
    .busy      (busy),
    .load_err  (load_err),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_ch_idx  (m_ch_idx),
    .m_ch_last (m_ch_last),
    .m_last    (m_last)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic set_fmap(input logic [15:0] base);
    for (int k = 0; k < N; k++) begin
      fmap[k*DW +: DW] = base + 16'(k);
    end
  endtask

  task automatic set_fmap_ones;
    for (int k = 0; k < N; k++) begin
      fmap[k*DW +: DW] = 16'hFFFF;
    end
  endtask

  task automatic check_word(input string tag, input int k, input logic [15:0] base);
    logic [31:0] exp_ch;
    logic [31:0] exp_chl;
`ifdef FMAP_STREAM_TX_CHLAST_EN
    exp_ch  = 32'(k / (H * W));
    exp_chl = 32'((k % (H * W)) == (H * W - 1));
`else
    exp_ch  = 32'd0;
    exp_chl = 32'd0;
`endif
    check($sformatf("%s_valid_w%0d", tag, k), 32'(m_valid), 32'd1);
    check($sformatf("%s_busy_w%0d", tag, k), 32'(busy), 32'd1);
    check($sformatf("%s_data_w%0d", tag, k), 32'(m_data), 32'(base + 16'(k)));
    check($sformatf("%s_last_w%0d", tag, k), 32'(m_last), 32'(k == N - 1));
    check($sformatf("%s_chidx_w%0d", tag, k), 32'(m_ch_idx), exp_ch);
    check($sformatf("%s_chlast_w%0d", tag, k), 32'(m_ch_last), exp_chl);
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_valid"}, 32'(m_valid), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_last"}, 32'(m_last), 32'd0);
  endtask

  task automatic start_frame;
    load = 1'b1;
    tick();
    load = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench timeout");
  end

  initial begin
    int e;
    int cyc;
    reset   = 1'b0;
    load    = 1'b0;
    m_ready = 1'b0;
    set_fmap(16'h0001);
    #2;
    check("rst_valid", 32'(m_valid), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_data", 32'(m_data), 32'd0);
    check("rst_last", 32'(m_last), 32'd0);
    check("rst_chlast", 32'(m_ch_last), 32'd0);
    check("rst_chidx", 32'(m_ch_idx), 32'd0);
    check("rst_lerr", 32'(load_err), 32'd0);
    tick();
    tick();
    reset = 1'b1;
    tick();

    // Full-throughput frame.
    m_ready = 1'b1;
    start_frame();
    for (int k = 0; k < N; k++) begin
      check_word("t1", k, 16'h0001);
      tick();
    end
    check_idle("t1_end");

    // Backpressure pattern 1,0,0 repeating.
    start_frame();
    e   = 0;
    cyc = 0;
    while (e < N && cyc < 60) begin
      m_ready = (cyc % 3 == 0);
      check_word("t2", e, 16'h0001);
      tick();
      if (m_ready) e++;
      cyc++;
    end
    check("t2_done", 32'(e), 32'(N));
    m_ready = 1'b1;
    check_idle("t2_end");

    // Load during SEND is ignored and flagged.
    start_frame();
    for (int k = 0; k < N; k++) begin
      check_word("t3", k, 16'h0001);
      if (k == 0) check("t3_lerr_idle", 32'(load_err), 32'd0);
      if (k == 2) begin
        load = 1'b1;
        set_fmap_ones();
      end
      if (k == 3) begin
        check("t3_lerr_pulse", 32'(load_err), 32'd1);
        load = 1'b0;
      end
      if (k == 4) check("t3_lerr_clear", 32'(load_err), 32'd0);
      tick();
    end
    check_idle("t3_end");
    set_fmap(16'h0001);

    // Asynchronous reset mid-frame aborts it.
    start_frame();
    for (int k = 0; k < 3; k++) begin
      check_word("t4a", k, 16'h0001);
      tick();
    end
    #2;
    reset = 1'b0;
    #1;
    check_idle("t4_async");
    check("t4_async_data", 32'(m_data), 32'd0);
    tick();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      tick();
      check($sformatf("t4_quiet_valid%0d", i), 32'(m_valid), 32'd0);
      check($sformatf("t4_quiet_busy%0d", i), 32'(busy), 32'd0);
    end
    start_frame();
    for (int k = 0; k < N; k++) begin
      check_word("t4b", k, 16'h0001);
      tick();
    end
    check_idle("t4_end");

    // Load on the final transfer is rejected; load on the next cycle is taken.
    start_frame();
    for (int k = 0; k < N; k++) begin
      check_word("t5a", k, 16'h0001);
      if (k == N - 1) load = 1'b1;
      tick();
    end
    check_idle("t5_gap");
    check("t5_lerr_pulse", 32'(load_err), 32'd1);
    set_fmap(16'h0011);
    tick();
    load = 1'b0;
    check("t5_lerr_clear", 32'(load_err), 32'd0);
    for (int k = 0; k < N; k++) begin
      check_word("t5b", k, 16'h0011);
      tick();
    end
    check_idle("t5_end");

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
